// File: rtl/tt_tern_pkg.sv
// Shared definitions for the ternary weight loader: code points, FSM states and
// helpers that derive beat count and row-index width from the row geometry.
package tt_tern_pkg;

    localparam logic [1:0] TERN_ZERO    = 2'b00;
    localparam logic [1:0] TERN_POS     = 2'b01;
    localparam logic [1:0] TERN_NEG     = 2'b11;
    localparam logic [1:0] TERN_ILLEGAL = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_READY,
        ST_RUN
    } state_t;

    function automatic int calc_beats(input int row_bits, input int in_w);
        return (row_bits + in_w - 1) / in_w;
    endfunction

    function automatic int calc_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic tern_illegal(input logic [1:0] code);
        return code == TERN_ILLEGAL;
    endfunction

    // Signed value of a legal code; illegal codes read as zero.
    function automatic int tern_value(input logic [1:0] code);
        case (code)
            TERN_POS: return 1;
            TERN_NEG: return -1;
            default:  return 0;
        endcase
    endfunction

endpackage

// File: rtl/tt_beat_assembler.sv
// Collects IN_W-bit beats into one row. The final beat is not stored: it is
// merged straight into the row output so the row commits on its own edge.
module tt_beat_assembler #(
    parameter int IN_W     = 8,
    parameter int ROW_BITS = 28,
    parameter int BEATS    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                accept,
    input  logic [IN_W-1:0]     beat,
    output logic [ROW_BITS-1:0] row,
    output logic                row_done
);

    localparam int CNT_W  = (BEATS <= 2) ? 1 : $clog2(BEATS);
    localparam int LAST_W = ROW_BITS - (BEATS - 1) * IN_W;

    logic [CNT_W-1:0] beat_cnt_q;
    logic             last_beat;

    assign last_beat = (beat_cnt_q == CNT_W'(BEATS - 1));
    assign row_done  = accept && last_beat;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            beat_cnt_q <= '0;
        end else if (accept) begin
            beat_cnt_q <= last_beat ? '0 : beat_cnt_q + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BEATS - 1; gi++) begin : g_slot
            logic [IN_W-1:0] slot_q;

            always_ff @(posedge clk) begin
                if (rst || clear) begin
                    slot_q <= '0;
                end else if (accept && beat_cnt_q == CNT_W'(gi)) begin
                    slot_q <= beat;
                end
            end

            assign row[gi*IN_W +: IN_W] = slot_q;
        end
    endgenerate

    // Bits of the last beat beyond ROW_BITS are dropped here.
    assign row[ROW_BITS-1 -: LAST_W] = beat[LAST_W-1:0];

endmodule

// File: rtl/tt_um_weight_loader.sv
// Loads MAX_OUT_LEN ternary weight rows over a narrow handshake bus, then
// streams them round-robin with their index while run_en is held high.
module tt_um_weight_loader
    import tt_tern_pkg::*;
#(
    parameter int IN_W        = 8,
    parameter int MAX_IN_LEN  = 14,
    parameter int MAX_OUT_LEN = 7,
    parameter int WIDTH       = 2,
    localparam int ROW_BITS   = WIDTH * MAX_IN_LEN,
    localparam int BEATS      = calc_beats(ROW_BITS, IN_W),
    localparam int IDX_W      = calc_idx_w(MAX_OUT_LEN)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_start,
    input  logic                in_valid,
    input  logic [IN_W-1:0]     in_data,
    output logic                in_ready,
    input  logic                run_en,
    output logic [ROW_BITS-1:0] row_out,
    output logic [IDX_W-1:0]    row_idx,
    output logic                row_valid,
    output logic                loaded,
    output logic                err
);

    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(MAX_OUT_LEN - 1);

    state_t                state_q;
    logic [IDX_W-1:0]      row_cnt_q;
    logic [IDX_W-1:0]      ptr_q;
    logic [ROW_BITS-1:0]   row_out_q;
    logic [IDX_W-1:0]      row_idx_q;
    logic                  row_valid_q;
    logic                  loaded_q;
    logic                  err_q;
    logic [ROW_BITS-1:0]   mem_q [MAX_OUT_LEN];

    logic                  accept;
    logic [ROW_BITS-1:0]   asm_row;
    logic                  row_done;
    logic                  row_bad;

    assign in_ready = (state_q == ST_LOAD);
    // A restart owns its cycle: any beat offered alongside load_start is dropped.
    assign accept   = in_valid && in_ready && !load_start;

    tt_beat_assembler #(
        .IN_W     (IN_W),
        .ROW_BITS (ROW_BITS),
        .BEATS    (BEATS)
    ) u_asm (
        .clk      (clk),
        .rst      (rst),
        .clear    (load_start),
        .accept   (accept),
        .beat     (in_data),
        .row      (asm_row),
        .row_done (row_done)
    );

    genvar gi;
    generate
        if (WIDTH == 2) begin : g_chk
            logic [MAX_IN_LEN-1:0] field_bad;
            for (gi = 0; gi < MAX_IN_LEN; gi++) begin : g_field
                assign field_bad[gi] = tern_illegal(asm_row[gi*WIDTH +: WIDTH]);
            end
            assign row_bad = |field_bad;
        end else begin : g_nochk
            assign row_bad = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAX_OUT_LEN; i++) begin
                mem_q[i] <= '0;
            end
        end else if (row_done) begin
            mem_q[row_cnt_q] <= asm_row;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            row_cnt_q   <= '0;
            ptr_q       <= '0;
            row_out_q   <= '0;
            row_idx_q   <= '0;
            row_valid_q <= 1'b0;
            loaded_q    <= 1'b0;
            err_q       <= 1'b0;
        end else if (load_start) begin
            state_q     <= ST_LOAD;
            row_cnt_q   <= '0;
            ptr_q       <= '0;
            row_valid_q <= 1'b0;
            loaded_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    row_valid_q <= 1'b0;
                end
                ST_LOAD: begin
                    if (row_done) begin
                        if (row_bad) begin
                            err_q <= 1'b1;
                        end
                        if (row_cnt_q == LAST_ROW) begin
                            row_cnt_q <= '0;
                            loaded_q  <= 1'b1;
                            state_q   <= ST_READY;
                        end else begin
                            row_cnt_q <= row_cnt_q + 1'b1;
                        end
                    end
                end
                ST_READY: begin
                    row_valid_q <= 1'b0;
                    if (run_en) begin
                        state_q   <= ST_RUN;
                        ptr_q     <= '0;
                        row_idx_q <= '0;
                    end
                end
                ST_RUN: begin
                    if (run_en) begin
                        row_out_q   <= mem_q[ptr_q];
                        row_idx_q   <= ptr_q;
                        row_valid_q <= 1'b1;
                        ptr_q       <= (ptr_q == LAST_ROW) ? '0 : ptr_q + 1'b1;
                    end else begin
                        state_q     <= ST_READY;
                        row_valid_q <= 1'b0;
                        ptr_q       <= '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign row_out   = row_out_q;
    assign row_idx   = row_idx_q;
    assign row_valid = row_valid_q;
    assign loaded    = loaded_q;
    assign err       = err_q;

endmodule
